// File: rtl/seq_mul_pkg.sv
// Shared constants for the sequential shift-and-add multiplier.
package seq_mul_pkg;

    // Default operand width and iteration counter width.
    localparam int SEQ_WIDTH = 32;
    localparam int SEQ_CNT_W = 6;

    // Controller state encoding.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/seq_mul32_cla_add64.sv
// 64-bit carry-lookahead adder: sixteen 4-bit lookahead groups whose
// group carries are chained from the least significant group upward.
module CLA_Add64 (
    input  logic [63:0] x,
    input  logic [63:0] y,
    input  logic        cIn,
    output logic [63:0] s,
    output logic        cOut
);

    logic [63:0] gen;
    logic [63:0] prop;
    logic [64:0] carry;

    // Bit generate/propagate, in-group lookahead carries and group carry-out.
    always_comb begin
        gen      = x & y;
        prop     = x ^ y;
        carry    = '0;
        carry[0] = cIn;
        for (int grp = 0; grp < 16; grp++) begin
            carry[4*grp+1] = gen[4*grp]
                           | (prop[4*grp] & carry[4*grp]);
            carry[4*grp+2] = gen[4*grp+1]
                           | (prop[4*grp+1] & gen[4*grp])
                           | (prop[4*grp+1] & prop[4*grp] & carry[4*grp]);
            carry[4*grp+3] = gen[4*grp+2]
                           | (prop[4*grp+2] & gen[4*grp+1])
                           | (prop[4*grp+2] & prop[4*grp+1] & gen[4*grp])
                           | (prop[4*grp+2] & prop[4*grp+1] & prop[4*grp] & carry[4*grp]);
            carry[4*grp+4] = gen[4*grp+3]
                           | (prop[4*grp+3] & gen[4*grp+2])
                           | (prop[4*grp+3] & prop[4*grp+2] & gen[4*grp+1])
                           | (prop[4*grp+3] & prop[4*grp+2] & prop[4*grp+1] & gen[4*grp])
                           | (prop[4*grp+3] & prop[4*grp+2] & prop[4*grp+1]
                              & prop[4*grp] & carry[4*grp]);
        end
    end

    assign s    = prop ^ carry[63:0];
    assign cOut = carry[64];

endmodule

// File: rtl/seq_mul32.sv
// Sequential unsigned 32x32 -> 64 shift-and-add multiplier. Each of the 32
// iterations adds the shifted multiplicand into the accumulator through
// CLA_Add64 when the current multiplier bit is set.
module seq_mul32
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               err
);

    // The adder is fixed at 64 bits, so the product width must match it.
    if (2 * WIDTH != 64) begin : gWidthCheck
        $error("seq_mul32: 2*WIDTH must equal 64");
    end

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;
    logic [63:0]        sum;
    logic               cOut;
    logic [2*WIDTH-1:0] accNext;

    CLA_Add64 uAdder (
        .x    (acc),
        .y    (mcand),
        .cIn  (1'b0),
        .s    (sum),
        .cOut (cOut)
    );

    // Accumulator value for this iteration: add only when the multiplier bit is set.
    always_comb begin
        accNext = acc;
        if (mplier[0]) begin
            accNext = sum;
        end
    end

    // Controller, operand shift registers, iteration counter and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        count  <= '0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= accNext;
                    // An unsigned 32x32 product cannot overflow 64 bits, so a
                    // carry out here means the datapath itself is faulty.
                    if (mplier[0]) begin
                        err <= err | cOut;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    if (count == LAST_ITER) begin
                        product <= accNext;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mul32.sv
// Self-checking bench for seq_mul32: table-driven vectors, corner-case
// sequences (ignored start, back-to-back, mid-run reset) and random operands
// checked against a plain-arithmetic product model.
module tb_seq_mul32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [63:0] vp;
    } vec_t;

    vec_t vecs [5];

    seq_mul32 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] wx;
        logic [63:0] wy;
        wx = {32'd0, x};
        wy = {32'd0, y};
        return wx * wy;
    endfunction

    // One multiply. If preStarted, start was already raised in the DONE cycle.
    // pulseAt >= 1 raises start for one cycle mid-run with different operands.
    // chain leaves start high with (na, nb) in the done cycle for a back-to-back op.
    task automatic runOp(input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] exp, input bit preStarted,
                         input int pulseAt, input bit chain,
                         input logic [31:0] na, input logic [31:0] nb);
        int busyCnt;
        int doneCnt;
        if (!preStarted) begin
            @(negedge clk);
            a     = av;
            b     = bv;
            start = 1'b1;
        end
        @(posedge clk);
        busyCnt = 0;
        doneCnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) doneCnt++;
            if (i == 0) begin
                start = 1'b0;
                a     = $urandom;
                b     = $urandom;
            end
            if (pulseAt > 0 && i == pulseAt) begin
                start = 1'b1;
                a     = ~av;
                b     = ~bv;
            end else if (pulseAt > 0 && i == pulseAt + 1) begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("busy_cycles", 64'(busyCnt), 64'd32);
        check("done_early",  64'(doneCnt), 64'd0);
        check("done_pulse",  {63'd0, done}, 64'd1);
        check("busy_at_done", {63'd0, busy}, 64'd0);
        check("product",     product, exp);
        check("err",         {63'd0, err}, 64'd0);
        if (chain) begin
            a     = na;
            b     = nb;
            start = 1'b1;
        end else begin
            @(negedge clk);
            check("done_one_cycle", {63'd0, done}, 64'd0);
            check("product_held",   product, exp);
        end
    endtask

    initial begin
        int doneCnt;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000};
        vecs[3] = '{32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",    {63'd0, busy}, 64'd0);
        check("rst_done",    {63'd0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_err",     {63'd0, err}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            runOp(vecs[i].va, vecs[i].vb, vecs[i].vp, 1'b0, 0, 1'b0, 32'd0, 32'd0);
        end

        // Start pulsed ten cycles into a run must not disturb it.
        runOp(32'h0001_2345, 32'h0000_0010, 64'h0000_0000_0012_3450, 1'b0, 10, 1'b0, 32'd0, 32'd0);

        // Start held through DONE: second op begins with no idle cycle.
        runOp(32'h0000_0009, 32'h0000_000B, 64'd99, 1'b0, 0, 1'b1, 32'd2, 32'd7);
        runOp(32'd2, 32'd7, 64'h0000_0000_0000_000E, 1'b1, 0, 1'b0, 32'd0, 32'd0);

        // Reset at iteration 16 abandons the run.
        @(negedge clk);
        a     = 32'h0000_ABCD;
        b     = 32'h0000_1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy",    {63'd0, busy}, 64'd0);
        check("midrst_done",    {63'd0, done}, 64'd0);
        check("midrst_product", product, 64'd0);
        rst_n = 1'b1;
        doneCnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        check("midrst_no_done", 64'(doneCnt), 64'd0);
        runOp(32'h0000_ABCD, 32'h0000_1234, model(32'h0000_ABCD, 32'h0000_1234),
              1'b0, 0, 1'b0, 32'd0, 32'd0);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            runOp(ra, rb, model(ra, rb), 1'b0, 0, 1'b0, 32'd0, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
